// File: rtl/ddram_arbiter.sv
// Purpose : three-way toggle-handshake arbiter in front of the single DDR3 (ddram) port.
// Latency : pending in IDLE at N -> mem_req toggles at N+2; mem_ack at M -> pN_ack/data at M+1.
// Backpressure: one transaction in flight; requesters stay pending (req != ack) until served.
//
// Ports:
//   clk_sys, reset            system clock, synchronous active-high reset
//   p0_*                      ROM loader writes (always write, address passes straight through)
//   p1_*                      cartridge ROM reads (always read, address passes straight through)
//   p2_*                      save-RAM read/write, relocated to SRAM_BASE + p2_addr
//   mem_*                     toggle-handshake DDR3 side; mem_dout valid when mem_ack == mem_req
//   busy                      high in ISSUE, WAIT and DRAIN
//
// Build option: define DDRAM_ARB_RR_EN to round-robin between p1 and p2 (p0 keeps absolute
// priority). Without it the order is fixed p0 > p1 > p2.
module ddram_arbiter #(
    parameter int             AW        = 24,
    parameter int             DW        = 16,
    parameter logic [AW-1:0]  SRAM_BASE = 24'hF00000,
    parameter int             SRAM_AW   = 15
) (
    input  logic               clk_sys,
    input  logic               reset,

    input  logic [AW-1:0]      p0_addr,
    input  logic [DW-1:0]      p0_din,
    input  logic               p0_req,
    output logic               p0_ack,

    input  logic [AW-1:0]      p1_addr,
    input  logic               p1_req,
    output logic               p1_ack,
    output logic [DW-1:0]      p1_dout,

    input  logic [SRAM_AW-1:0] p2_addr,
    input  logic               p2_we,
    input  logic [DW-1:0]      p2_din,
    input  logic               p2_req,
    output logic               p2_ack,
    output logic [DW-1:0]      p2_dout,

    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_din,
    output logic               mem_we,
    output logic               mem_req,
    input  logic               mem_ack,
    input  logic [DW-1:0]      mem_dout,

    output logic               busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [1:0] G_P0 = 2'd0;
    localparam logic [1:0] G_P1 = 2'd1;
    localparam logic [1:0] G_P2 = 2'd2;

    logic [1:0] state;
    logic [1:0] grant;
    logic [1:0] grant_nxt;

    // Toggle registers power up at 0 and are never touched by reset for mem_req, so an
    // in-flight DDR3 transaction keeps its handshake parity across a reset.
    logic mem_req_r = 1'b0;
    logic p0_ack_r  = 1'b0;
    logic p1_ack_r  = 1'b0;
    logic p2_ack_r  = 1'b0;

    logic pend0, pend1, pend2;
    logic any_pend;
    logic pick2;
    logic mem_done;

    logic [AW-1:0] p2_map;

    assign mem_req = mem_req_r;
    assign p0_ack  = p0_ack_r;
    assign p1_ack  = p1_ack_r;
    assign p2_ack  = p2_ack_r;

    assign pend0    = p0_req ^ p0_ack_r;
    assign pend1    = p1_req ^ p1_ack_r;
    assign pend2    = p2_req ^ p2_ack_r;
    assign any_pend = pend0 | pend1 | pend2;
    assign mem_done = (mem_ack == mem_req_r);

    assign busy = (state != S_IDLE);

    // Save-RAM window: zero-extend the save-RAM word address onto the window base.
    assign p2_map = SRAM_BASE + {{(AW-SRAM_AW){1'b0}}, p2_addr};

`ifdef DDRAM_ARB_RR_EN
    // 1 = p2 was the last of p1/p2 to be granted; starts at 1 so p1 wins the first tie.
    logic last_p2;

    assign pick2 = pend2 && (!pend1 || !last_p2);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            last_p2 <= 1'b1;
        end else if (state == S_IDLE && any_pend && !pend0) begin
            last_p2 <= pick2;
        end
    end
`else
    assign pick2 = pend2 && !pend1;
`endif

    always_comb begin
        grant_nxt = G_P0;
        if (pend0) begin
            grant_nxt = G_P0;
        end else if (pick2) begin
            grant_nxt = G_P2;
        end else if (pend1) begin
            grant_nxt = G_P1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= S_DRAIN;
            grant    <= G_P0;
            p0_ack_r <= p0_req;
            p1_ack_r <= p1_req;
            p2_ack_r <= p2_req;
            p1_dout  <= '0;
            p2_dout  <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_pend) begin
                        grant <= grant_nxt;
                        state <= S_ISSUE;
                        case (grant_nxt)
                            G_P0: begin
                                mem_addr <= p0_addr;
                                mem_din  <= p0_din;
                                mem_we   <= 1'b1;
                            end
                            G_P1: begin
                                mem_addr <= p1_addr;
                                mem_din  <= '0;
                                mem_we   <= 1'b0;
                            end
                            default: begin
                                mem_addr <= p2_map;
                                mem_din  <= p2_din;
                                mem_we   <= p2_we;
                            end
                        endcase
                    end
                end

                S_ISSUE: begin
                    mem_req_r <= ~mem_req_r;
                    state     <= S_WAIT;
                end

                S_WAIT: begin
                    if (mem_done) begin
                        state <= S_IDLE;
                        case (grant)
                            G_P0: p0_ack_r <= ~p0_ack_r;
                            G_P1: begin
                                p1_dout  <= mem_dout;
                                p1_ack_r <= ~p1_ack_r;
                            end
                            default: begin
                                // Writes leave the last read data in place.
                                if (!mem_we) begin
                                    p2_dout <= mem_dout;
                                end
                                p2_ack_r <= ~p2_ack_r;
                            end
                        endcase
                    end
                end

                default: begin
                    // DRAIN: let a transaction issued before reset finish before arbitrating.
                    if (mem_done) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddram_arbiter.sv
// Bench for ddram_arbiter: directed stimulus pushes expected DDR3 transactions and port acks
// into queues; a monitor pops and compares whenever mem_req or a pN_ack toggles.
// A behavioural DDR3 model with programmable latency answers the toggle handshake.
module tb_ddram_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;

    logic [23:0] p0_addr = '0;
    logic [15:0] p0_din  = '0;
    logic        p0_req  = 1'b0;
    logic        p0_ack;
    logic [23:0] p1_addr = '0;
    logic        p1_req  = 1'b0;
    logic        p1_ack;
    logic [15:0] p1_dout;
    logic [14:0] p2_addr = '0;
    logic        p2_we   = 1'b0;
    logic [15:0] p2_din  = '0;
    logic        p2_req  = 1'b0;
    logic        p2_ack;
    logic [15:0] p2_dout;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_we;
    logic        mem_req;
    logic        mem_ack  = 1'b0;
    logic [15:0] mem_dout = '0;
    logic        busy;

    ddram_arbiter dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .p0_addr (p0_addr),
        .p0_din  (p0_din),
        .p0_req  (p0_req),
        .p0_ack  (p0_ack),
        .p1_addr (p1_addr),
        .p1_req  (p1_req),
        .p1_ack  (p1_ack),
        .p1_dout (p1_dout),
        .p2_addr (p2_addr),
        .p2_we   (p2_we),
        .p2_din  (p2_din),
        .p2_req  (p2_req),
        .p2_ack  (p2_ack),
        .p2_dout (p2_dout),
        .mem_addr(mem_addr),
        .mem_din (mem_din),
        .mem_we  (mem_we),
        .mem_req (mem_req),
        .mem_ack (mem_ack),
        .mem_dout(mem_dout),
        .busy    (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc++;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [23:0] addr;
        logic        we;
        logic [15:0] din;
    } mexp_t;

    typedef struct {
        int          port;
        logic [15:0] dout;
    } aexp_t;

    mexp_t mq[$];
    aexp_t aq[$];

    // ---------------- DDR3 model ----------------
    logic [15:0] mem_arr [logic [23:0]];
    int          mem_lat  = 3;
    bit          mem_hold = 1'b0;
    bit          m_busy   = 1'b0;
    int          m_cnt    = 0;
    logic [23:0] m_addr;
    logic        m_we;
    logic [15:0] m_din;
    int          t_memack = 0;

    initial begin
        forever begin
            @(negedge clk_sys);
            if (!m_busy && (mem_req !== mem_ack)) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_addr = mem_addr;
                m_we   = mem_we;
                m_din  = mem_din;
            end
            if (m_busy && !mem_hold) begin
                m_cnt++;
                if (m_cnt >= mem_lat) begin
                    if (m_we) mem_arr[m_addr] = m_din;
                    else      mem_dout = mem_arr.exists(m_addr) ? mem_arr[m_addr] : 16'h0000;
                    mem_ack  = mem_req;
                    m_busy   = 1'b0;
                    t_memack = cyc;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic     pm_req   = 1'b0;
    logic [2:0] pa     = 3'b000;
    int       n_memreq = 0;
    int       n_ack [3] = '{0, 0, 0};
    int       t_memreq = 0;
    int       t_ack    = 0;

    initial begin
        logic [2:0] ca;
        mexp_t      me;
        aexp_t      ae;
        forever begin
            @(posedge clk_sys);
            #1;
            ca = {p2_ack, p1_ack, p0_ack};
            if (!reset) begin
                if (mem_req !== pm_req) begin
                    n_memreq++;
                    t_memreq = cyc;
                    chk("mem_txn_expected", 32'(mq.size() != 0), 1);
                    if (mq.size() != 0) begin
                        me = mq.pop_front();
                        chk("mem_addr", 32'(mem_addr), 32'(me.addr));
                        chk("mem_we", 32'(mem_we), 32'(me.we));
                        if (me.we) chk("mem_din", 32'(mem_din), 32'(me.din));
                    end
                end
                for (int i = 0; i < 3; i++) begin
                    if (ca[i] !== pa[i]) begin
                        n_ack[i]++;
                        t_ack = cyc;
                        chk("ack_expected", 32'(aq.size() != 0), 1);
                        if (aq.size() != 0) begin
                            ae = aq.pop_front();
                            chk("ack_port", 32'(i), 32'(ae.port));
                            if (i == 1) chk("p1_dout", 32'(p1_dout), 32'(ae.dout));
                            if (i == 2) chk("p2_dout", 32'(p2_dout), 32'(ae.dout));
                        end
                    end
                end
            end
            pm_req = mem_req;
            pa     = ca;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(input int maxc, input string name);
        int  n = 0;
        bit  done = 1'b0;
        while (!done && n < maxc) begin
            @(negedge clk_sys);
            n++;
            done = (p0_ack == p0_req) && (p1_ack == p1_req) && (p2_ack == p2_req) && !busy;
        end
        chk({name, "_done"}, 32'(done), 1);
    endtask

    initial begin
        int c0, m0, a0, a1, a2, i1, i2, n1, n2;
        bit fin;

        mem_arr[24'h000100] = 16'hA55A;

        // Reset / DRAIN state
        repeat (3) @(negedge clk_sys);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_acks", 32'({p2_ack, p1_ack, p0_ack}), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_p1_dout", 32'(p1_dout), 0);
        chk("rst_p2_dout", 32'(p2_dout), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("post_rst_idle", 32'(busy), 0);

        // Single ROM read, 5-cycle memory
        mem_lat = 5;
        mq.push_back('{addr: 24'h000100, we: 1'b0, din: 16'h0000});
        aq.push_back('{port: 1, dout: 16'hA55A});
        p1_addr = 24'h000100;
        c0 = cyc;
        p1_req = ~p1_req;
        wait_done(40, "rd1");
        chk("lat_req_to_memreq", 32'(t_memreq - c0), 2);
        chk("lat_memack_to_ack", 32'(t_ack - t_memack), 1);
        chk("rd1_p1_dout", 32'(p1_dout), 32'h0000A55A);

        // Save-RAM write then read
        mem_lat = 3;
        mq.push_back('{addr: 24'hF00010, we: 1'b1, din: 16'h1234});
        aq.push_back('{port: 2, dout: 16'h0000});
        p2_addr = 15'h0010; p2_din = 16'h1234; p2_we = 1'b1;
        p2_req = ~p2_req;
        wait_done(40, "sw");
        chk("sw_p2_dout_held", 32'(p2_dout), 0);
        mq.push_back('{addr: 24'hF00010, we: 1'b0, din: 16'h0000});
        aq.push_back('{port: 2, dout: 16'h1234});
        p2_we = 1'b0; p2_din = 16'hFFFF;
        p2_req = ~p2_req;
        wait_done(40, "sr");
        chk("sr_p2_dout", 32'(p2_dout), 32'h00001234);

        // Simultaneous requests: p0, p1, p2
        mem_lat = 2;
        m0 = n_memreq; a0 = n_ack[0]; a1 = n_ack[1]; a2 = n_ack[2];
        p0_addr = 24'h000020; p0_din = 16'hBEEF;
        p1_addr = 24'h000100;
        p2_addr = 15'h0010;   p2_we  = 1'b0;
        mq.push_back('{addr: 24'h000020, we: 1'b1, din: 16'hBEEF});
        mq.push_back('{addr: 24'h000100, we: 1'b0, din: 16'h0000});
        mq.push_back('{addr: 24'hF00010, we: 1'b0, din: 16'h0000});
        aq.push_back('{port: 0, dout: 16'h0000});
        aq.push_back('{port: 1, dout: 16'hA55A});
        aq.push_back('{port: 2, dout: 16'h1234});
        p0_req = ~p0_req; p1_req = ~p1_req; p2_req = ~p2_req;
        wait_done(80, "sim3");
        chk("sim3_memreqs", 32'(n_memreq - m0), 3);
        chk("sim3_ack0", 32'(n_ack[0] - a0), 1);
        chk("sim3_ack1", 32'(n_ack[1] - a1), 1);
        chk("sim3_ack2", 32'(n_ack[2] - a2), 1);

        // p1 and p2 re-requesting after every ack
`ifdef DDRAM_ARB_RR_EN
        n1 = 3; n2 = 3;
        for (int k = 0; k < 3; k++) begin
            mq.push_back('{addr: 24'h000100, we: 1'b0, din: 16'h0000});
            aq.push_back('{port: 1, dout: 16'hA55A});
            mq.push_back('{addr: 24'hF00010, we: 1'b0, din: 16'h0000});
            aq.push_back('{port: 2, dout: 16'h1234});
        end
`else
        n1 = 6; n2 = 1;
        for (int k = 0; k < 6; k++) begin
            mq.push_back('{addr: 24'h000100, we: 1'b0, din: 16'h0000});
            aq.push_back('{port: 1, dout: 16'hA55A});
        end
        mq.push_back('{addr: 24'hF00010, we: 1'b0, din: 16'h0000});
        aq.push_back('{port: 2, dout: 16'h1234});
`endif
        a1 = n_ack[1]; a2 = n_ack[2];
        i1 = 1; i2 = 1; fin = 1'b0;
        p1_req = ~p1_req; p2_req = ~p2_req;
        for (int k = 0; k < 300 && !fin; k++) begin
            @(negedge clk_sys);
            if (p1_ack == p1_req && i1 < n1) begin p1_req = ~p1_req; i1++; end
            if (p2_ack == p2_req && i2 < n2) begin p2_req = ~p2_req; i2++; end
            fin = (i1 == n1) && (i2 == n2) && (p1_ack == p1_req) && (p2_ack == p2_req) && !busy;
        end
        chk("arb_done", 32'(fin), 1);
        chk("arb_p1_grants", 32'(n_ack[1] - a1), 32'(n1));
        chk("arb_p2_grants", 32'(n_ack[2] - a2), 32'(n2));

        // Reset while waiting on DDR3 with a p2 read in flight
        mem_hold = 1'b1;
        mem_lat  = 3;
        mq.push_back('{addr: 24'hF00020, we: 1'b0, din: 16'h0000});
        p2_addr = 15'h0020; p2_we = 1'b0;
        p2_req = ~p2_req;
        fin = 1'b0;
        for (int k = 0; k < 20 && !fin; k++) begin
            @(negedge clk_sys);
            fin = m_busy;
        end
        chk("mr_outstanding", 32'(mem_req ^ mem_ack), 1);
        chk("mr_p2_pending", 32'(p2_req ^ p2_ack), 1);
        m0 = n_memreq;
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        chk("mr_acks_eq_reqs", 32'({p2_ack, p1_ack, p0_ack}), 32'({p2_req, p1_req, p0_req}));
        chk("mr_p1_dout_clr", 32'(p1_dout), 0);
        chk("mr_p2_dout_clr", 32'(p2_dout), 0);
        repeat (5) @(negedge clk_sys);
        chk("mr_drain_busy", 32'(busy), 1);
        chk("mr_no_new_req", 32'(n_memreq - m0), 0);
        mem_hold = 1'b0;
        fin = 1'b0;
        for (int k = 0; k < 20 && !fin; k++) begin
            @(negedge clk_sys);
            fin = !busy;
        end
        chk("mr_back_idle", 32'(busy), 0);
        chk("mr_mem_settled", 32'(mem_req ^ mem_ack), 0);

        // Loader stream of 256 writes
        mem_lat = 3;
        m0 = n_memreq; a0 = n_ack[0];
        for (int i = 0; i < 256; i++) begin
            p0_addr = 24'h100000 + 24'(i * 16);
            p0_din  = 16'(i * 257) ^ 16'h5A5A;
            mq.push_back('{addr: p0_addr, we: 1'b1, din: p0_din});
            aq.push_back('{port: 0, dout: 16'h0000});
            p0_req = ~p0_req;
            wait_done(40, "ld");
        end
        chk("ld_memreqs", 32'(n_memreq - m0), 256);
        chk("ld_acks", 32'(n_ack[0] - a0), 256);

        repeat (4) @(negedge clk_sys);
        chk("mem_queue_drained", 32'(mq.size()), 0);
        chk("ack_queue_drained", 32'(aq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
